branch_eval: RTL and testbench

Branch condition evaluator: the consumer side of the 4-bit SZCV flag register. It samples the registered flags (S, Z, C, V) when a conditional-branch request arrives and waits out any flag update already in flight. It then decides taken/not-taken and computes the 16-bit branch target. It sits between the decode stage and the PC register of the 16-bit core.

---
 rtl/branch_eval.sv | 112 +++++++++++
 tb/tb_branch_eval.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_eval.sv
// branch_eval: evaluates SZCV branch conditions and produces the next PC for the 16-bit core.
// Define BRANCH_STATS_EN to add saturating taken/not-taken counters.
module branch_eval (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  szcv,
  input  logic        flag_ld,
  input  logic        req,
  input  logic [2:0]  cond,
  input  logic [7:0]  disp,
  input  logic [15:0] pc_in,
  output logic        busy,
  output logic        done,
  output logic        taken,
  output logic [15:0] target,
  output logic        bad_cond
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0] taken_cnt,
  output logic [15:0] nottaken_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, HOLD, EVAL, RESP} state_t;

  state_t      state;
  logic [2:0]  cond_q;
  logic [7:0]  disp_q;
  logic [15:0] pc_q;

  logic        take;
  logic        reserved;
  logic [15:0] seq_pc;
  logic [15:0] br_pc;

  // Decision uses the live flag register, which is only consulted in EVAL.
  always_comb begin
    take     = 1'b0;
    reserved = 1'b0;
    case (cond_q)
      3'b000:  take = szcv[2];
      3'b001:  take = szcv[3] ^ szcv[0];
      3'b010:  take = szcv[2] | (szcv[3] ^ szcv[0]);
      3'b011:  take = ~szcv[2];
      3'b100:  take = 1'b1;
      3'b101:  take = szcv[1];
      3'b110:  take = ~szcv[1];
      default: reserved = 1'b1;
    endcase
    seq_pc = pc_q + 16'd1;
    br_pc  = seq_pc + {{8{disp_q[7]}}, disp_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cond_q   <= 3'b000;
      disp_q   <= 8'h00;
      pc_q     <= 16'h0000;
      busy     <= 1'b0;
      done     <= 1'b0;
      taken    <= 1'b0;
      target   <= 16'h0000;
      bad_cond <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            cond_q <= cond;
            disp_q <= disp;
            pc_q   <= pc_in;
            busy   <= 1'b1;
            state  <= flag_ld ? HOLD : EVAL;
          end
        end
        HOLD: begin
          if (!flag_ld) state <= EVAL;
        end
        EVAL: begin
          taken    <= take;
          target   <= take ? br_pc : seq_pc;
          bad_cond <= reserved;
          done     <= 1'b1;
          state    <= RESP;
        end
        RESP: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  // Counters advance on the same edge that publishes the decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt    <= 16'h0000;
      nottaken_cnt <= 16'h0000;
    end else if (state == EVAL) begin
      if (take) begin
        if (taken_cnt != 16'hFFFF) taken_cnt <= taken_cnt + 16'd1;
      end else begin
        if (nottaken_cnt != 16'hFFFF) nottaken_cnt <= nottaken_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_eval.sv
// Testbench for branch_eval: table-driven requests checked through a scoreboard queue,
// plus hand-written reset-abort and back-to-back sequences.
module tb_branch_eval;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  szcv;
  logic        flag_ld;
  logic        req;
  logic [2:0]  cond;
  logic [7:0]  disp;
  logic [15:0] pc_in;
  logic        busy;
  logic        done;
  logic        taken;
  logic [15:0] target;
  logic        bad_cond;
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt;
  logic [15:0] nottaken_cnt;
`endif

  branch_eval dut (
    .clk      (clk),
    .rst      (rst),
    .szcv     (szcv),
    .flag_ld  (flag_ld),
    .req      (req),
    .cond     (cond),
    .disp     (disp),
    .pc_in    (pc_in),
    .busy     (busy),
    .done     (done),
    .taken    (taken),
    .target   (target),
    .bad_cond (bad_cond)
`ifdef BRANCH_STATS_EN
    ,
    .taken_cnt    (taken_cnt),
    .nottaken_cnt (nottaken_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        taken;
    logic [15:0] target;
    logic        bad;
  } exp_t;

  typedef struct {
    string       name;
    logic [3:0]  szcv;
    logic [3:0]  szcv_new;
    int          ld;
    logic [2:0]  cond;
    logic [7:0]  disp;
    logic [15:0] pc;
    logic        exp_taken;
    logic [15:0] exp_target;
    logic        exp_bad;
  } vec_t;

  exp_t exp_q[$];
  int   assertCount = 0;
  int   failCount   = 0;
  int   doneSeen    = 0;
  int   model_tcnt  = 0;
  int   model_ncnt  = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      exp_t e;
      doneSeen++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("taken", {31'd0, taken}, {31'd0, e.taken});
        checkOutput("target", {16'd0, target}, {16'd0, e.target});
        checkOutput("bad_cond", {31'd0, bad_cond}, {31'd0, e.bad});
`ifdef BRANCH_STATS_EN
        if (e.taken) begin
          if (model_tcnt < 65535) model_tcnt++;
        end else begin
          if (model_ncnt < 65535) model_ncnt++;
        end
        checkOutput("taken_cnt", {16'd0, taken_cnt}, model_tcnt);
        checkOutput("nottaken_cnt", {16'd0, nottaken_cnt}, model_ncnt);
`endif
      end
    end
  end

  // Drives one request (with ld cycles of pending flag load) and checks latency and hold.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    int   lat;
    bit   seen;
    szcv    = v.szcv;
    cond    = v.cond;
    disp    = v.disp;
    pc_in   = v.pc;
    req     = 1'b1;
    flag_ld = (v.ld > 0);
    e.taken  = v.exp_taken;
    e.target = v.exp_target;
    e.bad    = v.exp_bad;
    exp_q.push_back(e);
    lat = 0;
    @(posedge clk);
    #1;
    cond  = v.cond ^ 3'b101;
    disp  = ~v.disp;
    pc_in = ~v.pc;
    if (v.ld == 0) begin
      flag_ld = 1'b1;
      @(posedge clk);
      #1;
      flag_ld = 1'b0;
      lat = 1;
    end else begin
      for (int i = 1; i < v.ld; i++) begin
        @(posedge clk);
        #1;
        lat++;
      end
      szcv    = v.szcv_new;
      flag_ld = 1'b0;
    end
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checkOutput({v.name, "_timeout"}, 32'd0, 32'd1);
      exp_q.delete();
    end else begin
      checkOutput({v.name, "_latency"}, lat, 2 + v.ld);
    end
    req = 1'b0;
    @(negedge clk);
    checkOutput({v.name, "_hold_taken"}, {31'd0, taken}, {31'd0, v.exp_taken});
    checkOutput({v.name, "_hold_target"}, {16'd0, target}, {16'd0, v.exp_target});
    checkOutput({v.name, "_done_pulse"}, {31'd0, done}, 32'd0);
    checkOutput({v.name, "_busy_clr"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[15];
    int   d1;
    int   d2;
    int   idx;
    int   base;

    vecs[0]  = '{"be_t",     4'b0100, 4'b0100, 0, 3'b000, 8'h05, 16'h0010, 1'b1, 16'h0016, 1'b0};
    vecs[1]  = '{"be_nt",    4'b0000, 4'b0000, 0, 3'b000, 8'h05, 16'h0010, 1'b0, 16'h0011, 1'b0};
    vecs[2]  = '{"blt_t",    4'b1000, 4'b1000, 0, 3'b001, 8'h10, 16'h0100, 1'b1, 16'h0111, 1'b0};
    vecs[3]  = '{"blt_nt",   4'b1001, 4'b1001, 0, 3'b001, 8'h10, 16'h0100, 1'b0, 16'h0101, 1'b0};
    vecs[4]  = '{"ble_z",    4'b0100, 4'b0100, 0, 3'b010, 8'hFE, 16'h0200, 1'b1, 16'h01FF, 1'b0};
    vecs[5]  = '{"bne_t",    4'b0000, 4'b0000, 0, 3'b011, 8'h7F, 16'h1234, 1'b1, 16'h12B4, 1'b0};
    vecs[6]  = '{"bne_wrap", 4'b0100, 4'b0100, 0, 3'b011, 8'h05, 16'hFFFF, 1'b0, 16'h0000, 1'b0};
    vecs[7]  = '{"b_neg",    4'b0000, 4'b0000, 0, 3'b100, 8'hF0, 16'h0002, 1'b1, 16'hFFF3, 1'b0};
    vecs[8]  = '{"bc_t",     4'b0010, 4'b0010, 0, 3'b101, 8'h80, 16'h8000, 1'b1, 16'h7F81, 1'b0};
    vecs[9]  = '{"bnc_nt",   4'b0010, 4'b0010, 0, 3'b110, 8'h80, 16'h8000, 1'b0, 16'h8001, 1'b0};
    vecs[10] = '{"bnc_wrap", 4'b1101, 4'b1101, 0, 3'b110, 8'h01, 16'hFFFE, 1'b1, 16'h0000, 1'b0};
    vecs[11] = '{"resv",     4'b1111, 4'b1111, 0, 3'b111, 8'h20, 16'h0040, 1'b0, 16'h0041, 1'b1};
    vecs[12] = '{"be_clr",   4'b0100, 4'b0100, 0, 3'b000, 8'h00, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vecs[13] = '{"blt_ld2",  4'b0000, 4'b1000, 2, 3'b001, 8'h03, 16'h0300, 1'b1, 16'h0304, 1'b0};
    vecs[14] = '{"be_ld1",   4'b0100, 4'b0000, 1, 3'b000, 8'h01, 16'h0050, 1'b0, 16'h0051, 1'b0};

    rst = 1'b1; szcv = 4'b0000; flag_ld = 1'b0; req = 1'b0;
    cond = 3'b000; disp = 8'h00; pc_in = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_taken", {31'd0, taken}, 32'd0);
    checkOutput("rst_target", {16'd0, target}, 32'd0);
    checkOutput("rst_bad", {31'd0, bad_cond}, 32'd0);
`ifdef BRANCH_STATS_EN
    checkOutput("rst_tcnt", {16'd0, taken_cnt}, 32'd0);
    checkOutput("rst_ncnt", {16'd0, nottaken_cnt}, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 15; i++) applyStimulus(vecs[i]);

    $display("[TB] reset abort during EVAL");
    szcv = 4'b0100; cond = 3'b000; disp = 8'h11; pc_in = 16'h0700; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_busy_eval", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_taken", {31'd0, taken}, 32'd0);
    checkOutput("abort_target", {16'd0, target}, 32'd0);
    rst = 1'b0;
    req = 1'b0;
    model_tcnt = 0;
    model_ncnt = 0;
    base = doneSeen;
    repeat (5) @(negedge clk);
    checkOutput("abort_no_done", doneSeen - base, 32'd0);

    $display("[TB] back-to-back BLE then BC");
    exp_q.push_back('{1'b1, 16'h0409, 1'b0});
    exp_q.push_back('{1'b0, 16'h0501, 1'b0});
    szcv = 4'b0001; cond = 3'b010; disp = 8'h08; pc_in = 16'h0400; req = 1'b1;
    @(posedge clk);
    #1;
    cond = 3'b101; disp = 8'h10; pc_in = 16'h0500;
    d1 = -1; d2 = -1; idx = 0;
    while (d2 < 0 && idx < 15) begin
      @(negedge clk);
      idx++;
      if (done === 1'b1) begin
        if (d1 < 0) d1 = idx;
        else d2 = idx;
      end
    end
    req = 1'b0;
    checkOutput("b2b_first_done", d1, 32'd2);
    checkOutput("b2b_spacing", d2 - d1, 32'd3);
`ifdef BRANCH_STATS_EN
    checkOutput("b2b_tcnt", {16'd0, taken_cnt}, 32'd1);
    checkOutput("b2b_ncnt", {16'd0, nottaken_cnt}, 32'd1);
`endif
    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
